// File: rtl/pipeline_ctrl_regs_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types
//   Types and constants shared by the pipeline register bank and its
//   stall/flush controller.
//   stage_act_t      : per-register action chosen each cycle
//   pipe_mem_state_t : data-memory wait tracker state
//   *_IDX            : default register indices of the classic 5-stage core
// ---------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        ADVANCE = 2'd0,  // q <= d, valid <= upstream valid
        HOLD    = 2'd1,  // keep payload and valid
        BUBBLE  = 2'd2   // payload loaded (don't-care), valid <= 0
    } stage_act_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_mem_state_t;

    localparam int IF_ID_IDX  = 0;
    localparam int ID_EX_IDX  = 1;
    localparam int EX_MEM_IDX = 2;
    localparam int MEM_WB_IDX = 3;

    localparam int PERF_W = 32;

endpackage

// File: rtl/pipeline_ctrl_regs_pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
//   One inter-stage register: DATA_W payload plus a valid tag, updated
//   according to a stage_act_t command.
//   clk, rst   : clock, synchronous active-high reset (clears payload + valid)
//   act        : ADVANCE / HOLD / BUBBLE for this cycle
//   d          : next payload
//   up_valid   : valid bit of the upstream source
//   q, valid   : registered payload and valid tag
// ---------------------------------------------------------------------------
module pipe_reg
    import rv32i_types::*;
#(
    parameter int DATA_W = 256
)(
    input  logic              clk,
    input  logic              rst,
    input  stage_act_t        act,
    input  logic [DATA_W-1:0] d,
    input  logic              up_valid,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] q_next;
    logic              valid_reg;
    logic              valid_next;

    always_comb begin
        q_next     = q_reg;
        valid_next = valid_reg;
        case (act)
            ADVANCE: begin
                q_next     = d;
                valid_next = up_valid;
            end
            BUBBLE: begin
                // Payload is loaded anyway so the bubble path needs no extra mux.
                q_next     = d;
                valid_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            q_reg     <= q_next;
            valid_reg <= valid_next;
        end
    end

    assign q     = q_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/pipeline_ctrl_regs.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_regs
//   Valid-tagged inter-stage register bank with priority-resolved stall,
//   flush and bubble control for the RV32I pipeline. Register i feeds stage
//   i+1. Also produces the PC load enable and the memory-wait stall.
//
//   Priority per cycle: memory wait > redirect > hazard stall > advance.
//
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     stage_d        : NUM_STAGES packed payload slices, slice i -> register i
//     imem_resp      : fetch presents a valid instruction
//     hazard_stall   : load-use hazard from decode
//     redirect       : taken branch/jump resolved in execute
//     mem_req        : MEM-stage instruction accesses data memory
//     dmem_resp      : data memory completes this cycle
//     stage_q        : register payloads
//     stage_valid    : per-register valid tags
//     load_pc        : PC update enable (combinational)
//     mem_stall      : memory-wait stall (combinational)
//     perf_*         : 32-bit wrapping counters
//
//   Build option: define PIPE_PERF_CNT_EN to instantiate the performance
//   counters; otherwise all perf_* outputs are tied to zero.
//
//   Parameter constraints: MEM_IDX < NUM_STAGES-1,
//   FLUSH_STAGES <= MEM_IDX, 1 <= HAZ_IDX < FLUSH_STAGES.
// ---------------------------------------------------------------------------
module pipeline_ctrl_regs
    import rv32i_types::*;
#(
    parameter int NUM_STAGES   = 4,
    parameter int DATA_W       = 256,
    parameter int MEM_IDX      = EX_MEM_IDX,
    parameter int FLUSH_STAGES = 2,
    parameter int HAZ_IDX      = ID_EX_IDX
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_d,
    input  logic                         imem_resp,
    input  logic                         hazard_stall,
    input  logic                         redirect,
    input  logic                         mem_req,
    input  logic                         dmem_resp,
    output logic [NUM_STAGES*DATA_W-1:0] stage_q,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic                         load_pc,
    output logic                         mem_stall,
    output logic [PERF_W-1:0]            perf_cycles,
    output logic [PERF_W-1:0]            perf_retired,
    output logic [PERF_W-1:0]            perf_stalls,
    output logic [PERF_W-1:0]            perf_flushes
);

    stage_act_t            act [NUM_STAGES];
    logic [NUM_STAGES-1:0] up_valid;
    pipe_mem_state_t       mem_state_reg;
    pipe_mem_state_t       mem_state_next;

    // Stall only while the MEM-stage instruction is real and still waiting.
    assign mem_stall = mem_req & stage_valid[MEM_IDX] & ~dmem_resp;

    // A redirect still reloads the PC while decode flags a hazard, because
    // the hazarding instruction is about to be flushed.
    assign load_pc = ~mem_stall & (redirect | (~hazard_stall & imem_resp));

    assign up_valid = {stage_valid[NUM_STAGES-2:0], imem_resp};

    // Action resolution. Redirect and hazard are ignored under a memory wait;
    // their sources keep presenting them until the wait clears.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            act[i] = ADVANCE;
            if (mem_stall) begin
                if (i <= MEM_IDX)
                    act[i] = HOLD;
                else if (i == MEM_IDX + 1)
                    act[i] = BUBBLE;
            end else if (redirect) begin
                if (i < FLUSH_STAGES)
                    act[i] = BUBBLE;
            end else if (hazard_stall) begin
                if (i < HAZ_IDX)
                    act[i] = HOLD;
                else if (i == HAZ_IDX)
                    act[i] = BUBBLE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            pipe_reg #(
                .DATA_W (DATA_W)
            ) u_reg (
                .clk      (clk),
                .rst      (rst),
                .act      (act[gi]),
                .d        (stage_d[gi*DATA_W +: DATA_W]),
                .up_valid (up_valid[gi]),
                .q        (stage_q[gi*DATA_W +: DATA_W]),
                .valid    (stage_valid[gi])
            );
        end
    endgenerate

    // Memory-wait tracker: observational only, it never gates the pipeline.
    always_comb begin
        mem_state_next = mem_state_reg;
        case (mem_state_reg)
            MEM_IDLE: if (mem_stall) mem_state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_resp) mem_state_next = MEM_IDLE;
            default:  mem_state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            mem_state_reg <= MEM_IDLE;
        else
            mem_state_reg <= mem_state_next;
    end

    // While waiting, the MEM-stage register is held, so it must stay valid.
    wait_holds_valid_a: assert property (
        @(posedge clk) disable iff (rst)
        (mem_state_reg == MEM_WAIT) |-> stage_valid[MEM_IDX]
    );

`ifdef PIPE_PERF_CNT_EN
    logic              retire_evt;
    logic              stall_evt;
    logic              flush_evt;
    logic [PERF_W-1:0] perf_cycles_reg;
    logic [PERF_W-1:0] perf_retired_reg;
    logic [PERF_W-1:0] perf_stalls_reg;
    logic [PERF_W-1:0] perf_flushes_reg;

    assign retire_evt = stage_valid[NUM_STAGES-1] & (act[NUM_STAGES-1] != HOLD);
    assign stall_evt  = (mem_state_reg == MEM_WAIT)
                      | (hazard_stall & ~mem_stall & ~redirect);
    assign flush_evt  = redirect & ~mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_reg  <= '0;
            perf_retired_reg <= '0;
            perf_stalls_reg  <= '0;
            perf_flushes_reg <= '0;
        end else begin
            perf_cycles_reg <= perf_cycles_reg + PERF_W'(1);
            if (retire_evt) perf_retired_reg <= perf_retired_reg + PERF_W'(1);
            if (stall_evt)  perf_stalls_reg  <= perf_stalls_reg  + PERF_W'(1);
            if (flush_evt)  perf_flushes_reg <= perf_flushes_reg + PERF_W'(1);
        end
    end

    assign perf_cycles  = perf_cycles_reg;
    assign perf_retired = perf_retired_reg;
    assign perf_stalls  = perf_stalls_reg;
    assign perf_flushes = perf_flushes_reg;
`else
    assign perf_cycles  = '0;
    assign perf_retired = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_regs.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl_regs
//   Directed-vector bench for pipeline_ctrl_regs. Each vector drives one
//   cycle of control inputs plus the fetch payload. The datapath between
//   registers is a pass-through (stage_d[i] = stage_q[i-1]), so a payload
//   tag travels unchanged to the last register. Tags expected to retire are
//   queued when issued; a monitor pops and compares each retiring payload.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl_regs;

    localparam int NS = 4;
    localparam int DW = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*DW-1:0]  stage_d;
    logic              imem_resp;
    logic              hazard_stall;
    logic              redirect;
    logic              mem_req;
    logic              dmem_resp;
    logic [NS*DW-1:0]  stage_q;
    logic [NS-1:0]     stage_valid;
    logic              load_pc;
    logic              mem_stall;
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_retired;
    logic [31:0]       perf_stalls;
    logic [31:0]       perf_flushes;
    logic [7:0]        d0;

    int                tests_run    = 0;
    int                tests_failed = 0;
    int                cyc          = 0;
    logic [DW-1:0]     sb_q [$];

    always #5 clk = ~clk;

    assign stage_d = {stage_q[(NS-1)*DW-1:0], {(DW-8){1'b0}}, d0};

    pipeline_ctrl_regs u_dut (
        .clk          (clk),
        .rst          (rst),
        .stage_d      (stage_d),
        .imem_resp    (imem_resp),
        .hazard_stall (hazard_stall),
        .redirect     (redirect),
        .mem_req      (mem_req),
        .dmem_resp    (dmem_resp),
        .stage_q      (stage_q),
        .stage_valid  (stage_valid),
        .load_pc      (load_pc),
        .mem_stall    (mem_stall),
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired),
        .perf_stalls  (perf_stalls),
        .perf_flushes (perf_flushes)
    );

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc%0d: got 0x%0h required 0x%0h", name, cyc, got, exp);
        end
    endtask

    // Scoreboard monitor: the last register presents a retiring instruction
    // whenever its valid tag is set (it is never held).
    always @(negedge clk) begin
        if (!rst && stage_valid[NS-1]) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL retire_unexpected cyc%0d: got 0x%0h required none",
                         cyc, stage_q[NS*DW-1 -: DW]);
            end else begin
                logic [DW-1:0] exp_payload;
                exp_payload = sb_q.pop_front();
                $display("[TB] retire payload 0x%0h", stage_q[NS*DW-1 -: DW]);
                check("retire_payload", stage_q[NS*DW-1 -: DW], exp_payload);
            end
        end
    end

    // One cycle: drive inputs, check combinational outputs mid-cycle, then
    // check registered state just after the capturing edge.
    task automatic apply(input bit r, input bit im, input logic [7:0] dv,
                         input bit hz, input bit rd, input bit mq, input bit dr,
                         input bit pu, input bit lp, input bit ms,
                         input logic [3:0] vld, input bit cq, input logic [7:0] q0);
        rst          = r;
        imem_resp    = im;
        d0           = dv;
        hazard_stall = hz;
        redirect     = rd;
        mem_req      = mq;
        dmem_resp    = dr;
        if (pu) sb_q.push_back(DW'(dv));
        #2;
        check("load_pc",   DW'(load_pc),   DW'(lp));
        check("mem_stall", DW'(mem_stall), DW'(ms));
        @(posedge clk);
        #1;
        cyc++;
        check("stage_valid", DW'(stage_valid), DW'(vld));
        if (cq) check("stage_q0", stage_q[DW-1:0], DW'(q0));
        $display("[TB] cyc %0d rst=%0b imem=%0b d0=%02h haz=%0b redir=%0b mreq=%0b dresp=%0b -> valid=%04b load_pc=%0b",
                 cyc, r, im, dv, hz, rd, mq, dr, stage_valid, load_pc);
    endtask

    task automatic chk_perf(input int cy, input int rt, input int st, input int fl);
        check("perf_cycles",  DW'(perf_cycles),  DW'(perf_exp(32'(cy))));
        check("perf_retired", DW'(perf_retired), DW'(perf_exp(32'(rt))));
        check("perf_stalls",  DW'(perf_stalls),  DW'(perf_exp(32'(st))));
        check("perf_flushes", DW'(perf_flushes), DW'(perf_exp(32'(fl))));
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < NS; i++)
            check("stage_q_reset", stage_q[i*DW +: DW], '0);
        chk_perf(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; imem_resp = 1'b0; hazard_stall = 1'b0; redirect = 1'b0;
        mem_req = 1'b0; dmem_resp = 1'b0; d0 = 8'h00;
        @(posedge clk);
        #1;
        //     r  im d0     hz rd mq dr pu lp ms vld      cq q0
        apply(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 8'h00);
        apply(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 8'h00);
        chk_reset_state();
        cyc = 0;
        // Fill the pipe.
        apply(0, 1, 8'h11, 0, 0, 0, 0, 1, 1, 0, 4'b0001, 1, 8'h11);
        apply(0, 1, 8'h12, 0, 0, 0, 0, 1, 1, 0, 4'b0011, 1, 8'h12);
        apply(0, 1, 8'h13, 0, 0, 0, 0, 1, 1, 0, 4'b0111, 1, 8'h13);
        apply(0, 1, 8'h14, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 1, 8'h14);
        check("stage_q3_fill", stage_q[NS*DW-1 -: DW], DW'(8'h11));
        apply(0, 1, 8'h15, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 1, 8'h15);
        apply(0, 1, 8'h16, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 1, 8'h16);
        chk_perf(6, 2, 0, 0);
        // Memory wait for three cycles, response on the fourth.
        apply(0, 1, 8'h17, 0, 0, 1, 0, 0, 0, 1, 4'b0111, 1, 8'h16);
        apply(0, 1, 8'h17, 0, 0, 1, 0, 0, 0, 1, 4'b0111, 1, 8'h16);
        apply(0, 1, 8'h17, 0, 0, 1, 0, 0, 0, 1, 4'b0111, 1, 8'h16);
        apply(0, 1, 8'h17, 0, 0, 1, 1, 0, 1, 0, 4'b1111, 1, 8'h17);
        check("stage_q3_after_wait", stage_q[NS*DW-1 -: DW], DW'(8'h14));
        chk_perf(10, 3, 3, 0);
        // Redirect with a full pipe flushes registers 0..1.
        apply(0, 1, 8'h18, 0, 1, 0, 0, 0, 1, 0, 4'b1100, 0, 8'h00);
        chk_perf(11, 4, 3, 1);
        // Hazard stall: register 0 holds, register 1 gets a bubble.
        apply(0, 1, 8'h20, 0, 0, 0, 0, 1, 1, 0, 4'b1001, 1, 8'h20);
        apply(0, 1, 8'h21, 0, 0, 0, 0, 1, 1, 0, 4'b0011, 1, 8'h21);
        apply(0, 1, 8'h22, 1, 0, 0, 0, 0, 0, 0, 4'b0101, 1, 8'h21);
        chk_perf(14, 6, 4, 1);
        apply(0, 1, 8'h22, 0, 0, 0, 0, 1, 1, 0, 4'b1011, 1, 8'h22);
        apply(0, 1, 8'h23, 0, 0, 0, 0, 0, 1, 0, 4'b0111, 1, 8'h23);
        // Redirect together with hazard: redirect wins.
        apply(0, 1, 8'h24, 1, 1, 0, 0, 0, 1, 0, 4'b1100, 0, 8'h00);
        chk_perf(17, 7, 4, 2);
        apply(0, 1, 8'h25, 0, 0, 0, 0, 1, 1, 0, 4'b1001, 1, 8'h25);
        apply(0, 1, 8'h26, 0, 0, 0, 0, 1, 1, 0, 4'b0011, 1, 8'h26);
        apply(0, 1, 8'h27, 0, 0, 0, 0, 0, 1, 0, 4'b0111, 1, 8'h27);
        // Redirect during a memory wait takes effect on the response cycle.
        apply(0, 1, 8'h28, 0, 1, 1, 0, 0, 0, 1, 4'b0111, 1, 8'h27);
        apply(0, 1, 8'h28, 0, 1, 1, 0, 0, 0, 1, 4'b0111, 1, 8'h27);
        chk_perf(22, 9, 5, 2);
        apply(0, 1, 8'h28, 0, 1, 1, 1, 0, 1, 0, 4'b1100, 0, 8'h00);
        chk_perf(23, 9, 6, 3);
        // Drain with no fetch.
        apply(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 1, 8'h00);
        apply(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 8'h00);
        chk_perf(25, 11, 6, 3);
        // Enter a memory wait, then reset in the middle of it.
        apply(0, 1, 8'h30, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 1, 8'h30);
        apply(0, 1, 8'h31, 0, 0, 0, 0, 0, 1, 0, 4'b0011, 1, 8'h31);
        apply(0, 1, 8'h32, 0, 0, 0, 0, 0, 1, 0, 4'b0111, 1, 8'h32);
        apply(0, 1, 8'h33, 0, 0, 1, 0, 0, 0, 1, 4'b0111, 1, 8'h32);
        apply(1, 1, 8'h33, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 1, 8'h00);
        chk_reset_state();
        cyc = 30;
        // Stray response after reset must be ignored.
        apply(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 1, 8'h00);
        apply(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 8'h00);
        chk_perf(2, 0, 0, 0);
        check("scoreboard_drained", DW'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
